// File: rtl/fifo_uart_tx.sv
`timescale 1ns/1ps
// fifo_uart_tx: pops bytes from a byte FIFO and sends them LSB-first as UART frames, new frames gated by CTS.
// Optional feature macro UART_TX_PARITY_EN appends an even-parity bit (8E1); left undefined the framing is 8N1.
module fifo_uart_tx #(
  parameter int c_CLKSPERBIT = 104,
  parameter int c_DATAWIDTH  = 8
) (
  input  logic                   i_clock,
  input  logic                   i_resetn,
  input  logic [c_DATAWIDTH-1:0] i_fifo_data,
  input  logic                   i_fifo_empty,
  output logic                   o_fifo_readen,
  input  logic                   i_ctsn,
  output logic                   o_tx,
  output logic                   o_busy
);

  localparam int BAUD_W = (c_CLKSPERBIT > 1) ? $clog2(c_CLKSPERBIT) : 1;
  localparam int BIT_W  = (c_DATAWIDTH > 1) ? $clog2(c_DATAWIDTH) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(c_CLKSPERBIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(c_DATAWIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  state_t                   state_reg, state_next;
  logic [BAUD_W-1:0]        baud_reg, baud_next;
  logic [BIT_W-1:0]         bit_reg, bit_next;
  logic [c_DATAWIDTH-1:0]   shift_reg, shift_next;
  logic [c_DATAWIDTH-1:0]   shift_shr;
  logic                     tx_reg, tx_next;
  logic                     busy_reg, busy_next;
  logic [1:0]               rst_sync_reg;
  logic                     rst_n_int;
  logic                     pop_go;
  logic                     bit_end;

  // Assert follows i_resetn at once; release is delayed two clocks so the FSM leaves reset cleanly.
  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      rst_sync_reg <= 2'b00;
    end else begin
      rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
  end

  assign rst_n_int = rst_sync_reg[1];

`ifdef UART_TX_PARITY_EN
  logic [c_DATAWIDTH:0] par_chain;
  logic                 parity_reg, parity_next;
  genvar gi;

  assign par_chain[0] = 1'b0;
  generate
    for (gi = 0; gi < c_DATAWIDTH; gi++) begin : g_par
      assign par_chain[gi+1] = par_chain[gi] ^ i_fifo_data[gi];
    end
  endgenerate
`endif

  // The pop is decided combinationally so the FIFO sees it on the same edge that captures the byte.
  assign pop_go        = (state_reg == ST_IDLE) && rst_n_int && !i_fifo_empty && !i_ctsn;
  assign o_fifo_readen = pop_go;
  assign bit_end       = (baud_reg == BAUD_LAST);
  assign shift_shr     = shift_reg >> 1;

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    tx_next    = tx_reg;
`ifdef UART_TX_PARITY_EN
    parity_next = parity_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        tx_next   = 1'b1;
        baud_next = '0;
        bit_next  = '0;
        if (pop_go) begin
          shift_next = i_fifo_data;
`ifdef UART_TX_PARITY_EN
          parity_next = par_chain[c_DATAWIDTH];
`endif
          state_next = ST_POP;
        end
      end
      ST_POP: begin
        // Line drops to the start level on the same edge that enters START.
        baud_next  = '0;
        tx_next    = 1'b0;
        state_next = ST_START;
      end
      ST_START: begin
        if (bit_end) begin
          baud_next  = '0;
          bit_next   = '0;
          tx_next    = shift_reg[0];
          state_next = ST_DATA;
        end else begin
          baud_next = baud_reg + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          baud_next = '0;
          if (bit_reg == BIT_LAST) begin
            bit_next = '0;
`ifdef UART_TX_PARITY_EN
            tx_next    = parity_reg;
            state_next = ST_PARITY;
`else
            tx_next    = 1'b1;
            state_next = ST_STOP;
`endif
          end else begin
            bit_next   = bit_reg + BIT_W'(1);
            shift_next = shift_shr;
            tx_next    = shift_shr[0];
          end
        end else begin
          baud_next = baud_reg + BAUD_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          baud_next  = '0;
          tx_next    = 1'b1;
          state_next = ST_STOP;
        end else begin
          baud_next = baud_reg + BAUD_W'(1);
        end
      end
`endif
      ST_STOP: begin
        tx_next = 1'b1;
        if (bit_end) begin
          baud_next  = '0;
          state_next = ST_IDLE;
        end else begin
          baud_next = baud_reg + BAUD_W'(1);
        end
      end
      default: begin
        tx_next    = 1'b1;
        baud_next  = '0;
        bit_next   = '0;
        state_next = ST_IDLE;
      end
    endcase
    busy_next = (state_next != ST_IDLE);
  end

  always_ff @(posedge i_clock or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_reg <= ST_IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
      busy_reg  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
      busy_reg  <= busy_next;
`ifdef UART_TX_PARITY_EN
      parity_reg <= parity_next;
`endif
    end
  end

  assign o_tx   = tx_reg;
  assign o_busy = busy_reg;

endmodule
